frame_wr_commutator: RTL and testbench

FRAME_WR_COMMUTATOR -- requirements
Module: frame_wr_commutator

---
 rtl/frame_wr_pkg.sv | 17 +
 rtl/strobe_sync.sv | 30 +++
 rtl/frame_wr_commutator.sv | 145 ++++++++++++++
 tb/tb_frame_wr_commutator.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_wr_pkg.sv
// Shared types and helpers for the frame write commutator.
package frame_wr_pkg;

  // Controller states; IDLE is the reset state.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRSET = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  // Width of a counter that must reach total-1.
  function automatic int CNT_W(input int total);
    return (total <= 2) ? 1 : $clog2(total);
  endfunction

endpackage

// File: rtl/strobe_sync.sv
// Two-flop synchronizer for the asynchronous word strobe, with rising-edge detect.
module strobe_sync (
  input  logic clk,
  input  logic rst,
  input  logic i_strob,
  output logic o_sync,
  output logic o_rise
);

  logic r_s1;
  logic r_s2;
  logic r_s2_d;

  // Synchronizer chain plus one delayed copy of its output for edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_s2_d <= 1'b0;
    end else begin
      r_s1   <= i_strob;
      r_s2   <= r_s1;
      r_s2_d <= r_s2;
    end
  end

  assign o_sync = r_s2;
  assign o_rise = r_s2 & ~r_s2_d;

endmodule

// File: rtl/frame_wr_commutator.sv
// Frame write commutator: one timed WE pulse per strobed word, addresses
// advance through the frame and banks rotate at each frame boundary.
//
//   state | meaning
//   IDLE  | waiting for strobe with en high
//   WRSET | word in progress, cntWE running, WE in its window
//   WAIT  | word done, waiting for strobe to drop
//   HALT  | one-shot frame complete, waiting for rearm
module frame_wr_commutator
  import frame_wr_pkg::*;
#(
  parameter int WORDS    = 20,
  parameter int ADR_W    = 5,
  parameter int WE_DELAY = 30,
  parameter int WE_LEN   = 2,
  parameter int BANKS    = 2,
  parameter int ONE_SHOT = 0,
  localparam int BANK_W  = (BANKS > 1) ? $clog2(BANKS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              strob,
  input  logic              rearm,
  output logic [ADR_W-1:0]  wrAdr,
  output logic [BANK_W-1:0] bank,
  output logic              WE,
  output logic              full,
  output logic              overrun,
  output logic              busy
);

  localparam int CW = CNT_W(WE_DELAY + WE_LEN);
  localparam logic [CW-1:0]     CNT_ON    = CW'(WE_DELAY);
  localparam logic [CW-1:0]     CNT_LAST  = CW'(WE_DELAY + WE_LEN - 1);
  localparam logic [ADR_W-1:0]  ADR_LAST  = ADR_W'(WORDS - 1);
  localparam logic [BANK_W-1:0] BANK_LAST = BANK_W'(BANKS - 1);

  state_t              r_state;
  state_t              w_state_n;
  logic [CW-1:0]       r_cnt;
  logic [CW-1:0]       w_cnt_n;
  logic                w_we_n;
  logic                r_we;
  logic                r_full;
  logic                r_ovr;
  logic                r_wrap;
  logic [ADR_W-1:0]    r_adr;
  logic [BANK_W-1:0]   r_bank;
  logic                w_sync;
  logic                w_rise;
  logic                w_word_done;

  strobe_sync u_sync (
    .clk     (clk),
    .rst     (rst),
    .i_strob (strob),
    .o_sync  (w_sync),
    .o_rise  (w_rise)
  );

  assign w_word_done = (r_state == ST_WRSET) && (r_cnt == CNT_LAST);

  // Next state and next cntWE; WE is derived from these so it is registered
  // in lock-step with the counter value it belongs to.
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_sync && en) begin
          w_state_n = ST_WRSET;
          w_cnt_n   = '0;
        end
      end
      ST_WRSET: begin
        if (r_cnt == CNT_LAST) w_state_n = ST_WAIT;
        else                   w_cnt_n   = r_cnt + 1'b1;
      end
      ST_WAIT: begin
        if (!w_sync) w_state_n = ((ONE_SHOT != 0) && r_wrap) ? ST_HALT : ST_IDLE;
      end
      ST_HALT: begin
        if (rearm) w_state_n = ST_IDLE;
      end
      default: w_state_n = ST_IDLE;
    endcase
    w_we_n = (w_state_n == ST_WRSET) && (w_cnt_n >= CNT_ON) && (w_cnt_n <= CNT_LAST);
  end

  // State, word timer and registered write enable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_we    <= w_we_n;
    end
  end

  // Address/bank advance at word end; frame wrap pulses full and rotates the bank.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_adr  <= '0;
      r_bank <= '0;
      r_full <= 1'b0;
      r_wrap <= 1'b0;
    end else begin
      r_full <= 1'b0;
      if (r_state == ST_IDLE && w_state_n == ST_WRSET) begin
        r_wrap <= 1'b0;
      end else if (w_word_done) begin
        if (r_adr == ADR_LAST) begin
          r_adr  <= '0;
          r_full <= 1'b1;
          r_wrap <= 1'b1;
          r_bank <= (r_bank == BANK_LAST) ? '0 : r_bank + 1'b1;
        end else begin
          r_adr  <= r_adr + 1'b1;
          r_wrap <= 1'b0;
        end
      end else if (r_state == ST_HALT) begin
        r_adr <= '0;
      end
    end
  end

  // Sticky overrun on a second strobe edge inside a word; rearm wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                               r_ovr <= 1'b0;
    else if (rearm)                         r_ovr <= 1'b0;
    else if (w_rise && r_state == ST_WRSET) r_ovr <= 1'b1;
  end

  assign wrAdr   = r_adr;
  assign bank    = r_bank;
  assign WE      = r_we;
  assign full    = r_full;
  assign overrun = r_ovr;
  assign busy    = (r_state == ST_WRSET) || (r_state == ST_WAIT);

endmodule

// File: tb/tb_frame_wr_commutator.sv
// Bench for frame_wr_commutator: a default instance and a one-shot instance
// share stimulus; a timestamp-based word model is checked every cycle, plus
// hand-computed literal expectations at key points.
module tb_frame_wr_commutator;

  localparam int WORDS = 20;
  localparam int D     = 30;
  localparam int L     = 2;
  localparam int NB    = 2;

  localparam int M_IDLE  = 0;
  localparam int M_WRITE = 1;
  localparam int M_WAIT  = 2;
  localparam int M_HALT  = 3;

  logic clk, rst, en, strob, rearm;
  logic [4:0] wrAdr0, wrAdr1;
  logic [0:0] bank0, bank1;
  logic WE0, WE1, full0, full1, ovr0, ovr1, busy0, busy1;

  int n_checks = 0;
  int n_fail   = 0;

  frame_wr_commutator dut0 (
    .clk(clk), .rst(rst), .en(en), .strob(strob), .rearm(rearm),
    .wrAdr(wrAdr0), .bank(bank0), .WE(WE0), .full(full0),
    .overrun(ovr0), .busy(busy0)
  );

  frame_wr_commutator #(.ONE_SHOT(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .strob(strob), .rearm(rearm),
    .wrAdr(wrAdr1), .bank(bank1), .WE(WE1), .full(full1),
    .overrun(ovr1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Word-level model: a word is described by the cycle it started on; all
  // timing follows from elapsed cycles since that start.
  typedef struct {
    int mode;
    int ws;
    int adr;
    int bank;
    bit wrapped;
    bit ovr;
    bit full;
    bit we;
  } mdl_t;

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m.mode = M_IDLE; m.ws = 0; m.adr = 0; m.bank = 0;
    m.wrapped = 0; m.ovr = 0; m.full = 0; m.we = 0;
    return m;
  endfunction

  function automatic mdl_t mdl_step(input mdl_t m, input int cyc, input bit sync,
                                    input bit rise, input bit en_i, input bit rearm_i,
                                    input bit oneshot);
    mdl_t n = m;
    n.full = 0;
    if (rearm_i) n.ovr = 0;
    else if (rise && m.mode == M_WRITE) n.ovr = 1;
    case (m.mode)
      M_IDLE: if (sync && en_i) begin n.mode = M_WRITE; n.ws = cyc; n.wrapped = 0; end
      M_WRITE: begin
        if ((cyc - 1) - m.ws == D + L - 1) begin
          n.mode = M_WAIT;
          if (m.adr == WORDS - 1) begin
            n.adr = 0; n.full = 1; n.bank = (m.bank + 1) % NB; n.wrapped = 1;
          end else begin
            n.adr = m.adr + 1;
          end
        end
      end
      M_WAIT: if (!sync) n.mode = (oneshot && m.wrapped) ? M_HALT : M_IDLE;
      default: begin
        n.adr = 0;
        if (rearm_i) n.mode = M_IDLE;
      end
    endcase
    n.we = (n.mode == M_WRITE) && (cyc - n.ws >= D) && (cyc - n.ws <= D + L - 1);
    return n;
  endfunction

  mdl_t m0, m1;
  bit   sh1, sh2, sh3;
  int   cyc;

  // Model advance on each clock; strob seen through a two-cycle delay line.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m0 = mdl_reset(); m1 = mdl_reset();
      sh1 = 0; sh2 = 0; sh3 = 0;
    end else begin
      cyc++;
      m0 = mdl_step(m0, cyc, sh2, sh2 & ~sh3, en, rearm, 1'b0);
      m1 = mdl_step(m1, cyc, sh2, sh2 & ~sh3, en, rearm, 1'b1);
      sh3 = sh2; sh2 = sh1; sh1 = strob;
    end
  end

  int we_cnt0 = 0, we_cnt1 = 0;
  bit we_prev0 = 0, we_prev1 = 0;

  // Per-cycle comparison of both instances against the model.
  always @(posedge clk) begin
    #1;
    chk("wrAdr0", wrAdr0, m0.adr);
    chk("bank0", bank0, m0.bank);
    chk("WE0", WE0, m0.we);
    chk("full0", full0, m0.full);
    chk("overrun0", ovr0, m0.ovr);
    chk("busy0", busy0, (m0.mode == M_WRITE || m0.mode == M_WAIT));
    chk("wrAdr1", wrAdr1, m1.adr);
    chk("bank1", bank1, m1.bank);
    chk("WE1", WE1, m1.we);
    chk("full1", full1, m1.full);
    chk("overrun1", ovr1, m1.ovr);
    chk("busy1", busy1, (m1.mode == M_WRITE || m1.mode == M_WAIT));
    if (WE0 && !we_prev0) we_cnt0++;
    if (WE1 && !we_prev1) we_cnt1++;
    we_prev0 = WE0;
    we_prev1 = WE1;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Snapshots taken by word() at fixed offsets after the strobe goes high.
  logic [4:0] a33, a35, a1_33;
  logic we33, we34, we35, b35, f35, f36, we1_33;

  // One 5-cycle strobe pulse followed by enough idle time for the word to finish.
  task automatic word();
    strob = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (k == 5) strob = 1'b0;
      if (k == 33) begin a33 = wrAdr0; we33 = WE0; a1_33 = wrAdr1; we1_33 = WE1; end
      if (k == 34) we34 = WE0;
      if (k == 35) begin a35 = wrAdr0; we35 = WE0; b35 = bank0; f35 = full0; end
      if (k == 36) f36 = full0;
    end
  endtask

  // Strobe with a low glitch inside WRSET; rearm optionally held across the new edge.
  task automatic glitch_word(input bit hold_rearm);
    strob = 1'b1;
    for (int k = 1; k <= 50; k++) begin
      step();
      if (k == 5)  strob = 1'b0;
      if (k == 8)  strob = 1'b1;
      if (k == 42) strob = 1'b0;
      if (hold_rearm && k == 9)  rearm = 1'b1;
      if (hold_rearm && k == 13) rearm = 1'b0;
    end
  endtask

  int base;

  initial begin
    cyc = 0;
    rst = 1'b0; en = 1'b1; strob = 1'b0; rearm = 1'b0;
    #1;
    chk("reset WE", WE0, 0);
    chk("reset wrAdr", wrAdr0, 0);
    chk("reset bank", bank0, 0);
    chk("reset busy", busy0, 0);
    chk("reset full", full0, 0);
    chk("reset overrun", ovr0, 0);
    repeat (3) step();
    rst = 1'b1;
    repeat (2) step();

    // First word: WE on WRSET cycles 30..31 at address 0, address 1 after.
    word();
    chk("w1 WE@30", we33, 1);
    chk("w1 WE@31", we34, 1);
    chk("w1 wrAdr during WE", a33, 0);
    chk("w1 WE after", we35, 0);
    chk("w1 wrAdr after", a35, 1);

    // Words 2..20: frame wrap on the 20th.
    for (int w = 2; w <= 20; w++) word();
    chk("w20 full pulse", f35, 1);
    chk("w20 wrAdr wrap", a35, 0);
    chk("w20 bank", b35, 1);
    chk("w20 full one cycle", f36, 0);
    chk("oneshot halted busy", busy1, 0);
    chk("oneshot halted wrAdr", wrAdr1, 0);

    // 21st strobe ignored by the halted one-shot instance.
    word();
    chk("oneshot WE count", we_cnt1, 20);
    chk("default WE count", we_cnt0, 21);

    rearm = 1'b1; step(); rearm = 1'b0; step();
    word();
    chk("oneshot rearm WE", we1_33, 1);
    chk("oneshot rearm wrAdr", a1_33, 0);
    chk("default w22 wrAdr", a33, 1);

    for (int w = 23; w <= 40; w++) word();
    chk("w40 bank", bank0, 0);
    chk("w40 wrAdr", wrAdr0, 0);

    // Second strobe edge inside WRSET: overrun, still a single write.
    base = we_cnt0;
    glitch_word(1'b0);
    chk("overrun set", ovr0, 1);
    chk("overrun single WE", we_cnt0 - base, 1);
    rearm = 1'b1; step(); rearm = 1'b0; step();
    chk("overrun cleared", ovr0, 0);

    // rearm coinciding with the extra edge keeps overrun clear.
    glitch_word(1'b1);
    chk("rearm priority", ovr0, 0);

    // en low blocks start; en rising with strobe high starts next cycle;
    // en dropping mid-word does not abort the word.
    base = we_cnt0;
    en = 1'b0; strob = 1'b1;
    repeat (10) step();
    chk("en=0 busy", busy0, 0);
    chk("en=0 WE", WE0, 0);
    en = 1'b1;
    step();
    chk("en rise busy", busy0, 1);
    strob = 1'b0;
    repeat (4) step();
    en = 1'b0;
    repeat (40) step();
    en = 1'b1;
    chk("en drop word done", we_cnt0 - base, 1);

    for (int w = 44; w <= 61; w++) word();
    chk("w61 wrAdr", wrAdr0, 1);
    chk("w61 bank", bank0, 1);

    // Reset during the WE window.
    strob = 1'b1;
    repeat (33) step();
    chk("pre-reset WE", WE0, 1);
    rst = 1'b0;
    #1;
    chk("rst WE", WE0, 0);
    chk("rst wrAdr", wrAdr0, 0);
    chk("rst bank", bank0, 0);
    chk("rst full", full0, 0);
    chk("rst busy", busy0, 0);
    strob = 1'b0;
    repeat (2) step();
    rst = 1'b1;
    step();

    word();
    chk("post-reset wrAdr during WE", a33, 0);
    chk("post-reset WE", we33, 1);
    chk("post-reset wrAdr after", a35, 1);

    repeat (3) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
